// File: rtl/pll_lock_supervisor_pkg.sv
// rtl/pll_lock_supervisor_pkg.sv - shared state encoding and sizing helpers for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int RETRY_W = 4;

    // Counter must hold the largest of the three programmed intervals.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL control and system-reset status bundle
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    logic               pll_lock_i;
    logic               clear_fault_i;
    logic               pll_reset_o;
    logic               sys_rst_n_o;
    logic               locked_o;
    logic               fault_o;
    logic               lost_lock_o;
    logic [RETRY_W-1:0] retry_count_o;

    modport master (
        input  pll_lock_i,
        input  clear_fault_i,
        output pll_reset_o,
        output sys_rst_n_o,
        output locked_o,
        output fault_o,
        output lost_lock_o,
        output retry_count_o
    );

    modport slave (
        output pll_lock_i,
        output clear_fault_i,
        input  pll_reset_o,
        input  sys_rst_n_o,
        input  locked_o,
        input  fault_o,
        input  lost_lock_o,
        input  retry_count_o
    );

endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// rtl/pll_lock_supervisor_sync.sv - multi-flop synchronizer with asynchronous active-low clear
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - drives PLL reset, qualifies lock, retries on timeout and gates system reset
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_CYCLES        = 270,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master bus
);

    localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

    pll_state_e         state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic               lock_s;
    logic               pll_reset;
    logic               sys_rst_n;
    logic               locked;
    logic               fault;
    logic               lost_lock;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_next;
    logic               fail_now;
    logic               fail_to_fault;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock_i),
        .q     (lock_s)
    );

    assign cnt_inc       = (cnt == '1) ? cnt : cnt + CW'(1);
    assign retry_next    = (retry == MAX_R) ? retry : retry + RETRY_W'(1);
    assign fail_to_fault = (retry_next == MAX_R);

    // Lock lost during STABILIZE is chatter and costs an attempt, same as a timeout.
    always_comb begin
        fail_now = 1'b0;
        if (state == WAIT_LOCK && !lock_s && cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) fail_now = 1'b1;
        if (state == STABILIZE && !lock_s) fail_now = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            lost_lock <= 1'b0;
            retry     <= '0;
        end else begin
            lost_lock <= 1'b0;
            if (fail_now) begin
                state     <= fail_to_fault ? FAULT : RESET_PLL;
                cnt       <= '0;
                pll_reset <= 1'b1;
                fault     <= fail_to_fault;
                retry     <= retry_next;
            end else begin
                case (state)
                    RESET_PLL: begin
                        if (cnt == CW'(RESET_CYCLES - 1)) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABILIZE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    STABILIZE: begin
                        if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                            state     <= RUN;
                            cnt       <= '0;
                            sys_rst_n <= 1'b1;
                            locked    <= 1'b1;
                            retry     <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state     <= RESET_PLL;
                            cnt       <= '0;
                            pll_reset <= 1'b1;
                            sys_rst_n <= 1'b0;
                            locked    <= 1'b0;
                            lost_lock <= 1'b1;
                        end
                    end
                    FAULT: begin
                        if (bus.clear_fault_i) begin
                            state <= RESET_PLL;
                            cnt   <= '0;
                            retry <= '0;
                            fault <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= RESET_PLL;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        sys_rst_n <= 1'b0;
                        locked    <= 1'b0;
                        fault     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_reset_o   = pll_reset;
    assign bus.sys_rst_n_o   = sys_rst_n;
    assign bus.locked_o      = locked;
    assign bus.fault_o       = fault;
    assign bus.lost_lock_o   = lost_lock;
    assign bus.retry_count_o = retry;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the fabric PLL from the reference-clock side. It drives the PLL RESET input, watches the asynchronous LOCK output, retries on lock timeout, and holds the system reset until lock has been stable for a programmed time. It sits between the 27 MHz board clock, the PLL wrapper, and the reset tree of the PLL-clocked logic. It also reports lock loss and a persistent fault after repeated failures.

Parameters:
RESET_CYCLES, 270, PLL reset pulse width in clk cycles (10 us at 27 MHz); minimum 1.
LOCK_TIMEOUT_CYCLES, 27000, maximum clk cycles allowed in WAIT_LOCK before a retry (1 ms).
LOCK_STABLE_CYCLES, 2700, consecutive clk cycles of synchronized lock required before the system is released (100 us).
MAX_RETRIES, 7, failed attempts that cause entry to FAULT; range 1..15.
SYNC_STAGES, 2, flops in the lock synchronizer; minimum 2.

Ports:
clk  input  1  27 MHz reference clock, the same clock that feeds the PLL clkin.
rst_n  input  1  asynchronous active-low reset.
pll_lock_i  input  1  PLL LOCK; asynchronous to clk.
clear_fault_i  input  1  synchronous to clk; exits FAULT.
pll_reset_o  output  1  drives PLL RESET, active high.
sys_rst_n_o  output  1  active-low reset for PLL-clocked logic. Downstream logic re-synchronizes it.
locked_o  output  1  high only in RUN.
fault_o  output  1  high only in FAULT.
lost_lock_o  output  1  one-cycle pulse when lock drops in RUN.
retry_count_o  output  4  number of failed attempts since the last RUN, reset, or fault clear.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: state=RESET_PLL, cnt=0, pll_reset_o=1, sys_rst_n_o=0, locked_o=0, fault_o=0, lost_lock_o=0, retry_count_o=0, synchronizer flops=0.
- Synchronizer: lock_s is pll_lock_i after SYNC_STAGES flops. The FSM uses only lock_s.
- Counter: cnt is unsigned, width clog2(max(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1). It clears on every state change and never wraps.
- States and transitions:
  - RESET_PLL:
    - pll_reset_o=1. cnt counts up.
    - When cnt==RESET_CYCLES-1: go to WAIT_LOCK; pll_reset_o=0 from the next cycle.
  - WAIT_LOCK:
    - pll_reset_o=0.
    - If lock_s=1: go to STABILIZE.
    - Else if cnt==LOCK_TIMEOUT_CYCLES-1: record a failed attempt (see failed-attempt rule).
    - Otherwise cnt counts up.
  - STABILIZE:
    - If lock_s=0: record a failed attempt (chatter counts as a failure).
    - Else if cnt==LOCK_STABLE_CYCLES-1: go to RUN.
    - Otherwise cnt counts up.
  - RUN:
    - sys_rst_n_o=1, locked_o=1, retry_count_o=0.
    - If lock_s=0: pulse lost_lock_o for exactly one cycle; sys_rst_n_o=0 and locked_o=0 in that same cycle; go to RESET_PLL. This does not increment the retry count.
  - FAULT:
    - pll_reset_o=1, sys_rst_n_o=0, fault_o=1.
    - If clear_fault_i=1: go to RESET_PLL, retry_count_o=0, fault_o=0.
- Failed-attempt rule:
  - retry_count_o increments by 1.
  - If the new value equals MAX_RETRIES: go to FAULT. Otherwise go to RESET_PLL.
  - The count saturates at MAX_RETRIES.
- sys_rst_n_o=0 in every state except RUN.
- Outputs change on the clock edge of the state transition, so each output reflects the new state.
- Latency: from the first clk edge that samples pll_lock_i=1 in WAIT_LOCK to sys_rst_n_o=1 is SYNC_STAGES + LOCK_STABLE_CYCLES + 1 cycles, provided lock stays high.
- Simultaneous events:
  - In WAIT_LOCK, lock_s=1 on the timeout cycle wins: go to STABILIZE.
  - clear_fault_i is ignored outside FAULT.
- rst_n asserted mid-operation: immediate return to reset values, including the asynchronous clear of the synchronizer.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT}, 3-bit encoding;
  - the function that computes the counter width.
- Sub-module sync_ff (parameter STAGES, async active-low clear) is reused for any other asynchronous status inputs.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2.
- Nominal lock:
  - Release rst_n; raise pll_lock_i 6 cycles later.
  - pll_reset_o is high for exactly 4 cycles.
  - sys_rst_n_o and locked_o rise 11 cycles after the first edge that samples lock=1.
  - retry_count_o=0.
- Lock timeout to fault:
  - Hold pll_lock_i=0.
  - retry_count_o steps 1, 2, 3 (one step per 4+20 cycles).
  - At 3: fault_o=1, pll_reset_o=1, sys_rst_n_o=0.
  - Pulse clear_fault_i: fault_o=0, retry_count_o=0, new 4-cycle reset pulse.
- Lock chatter:
  - Lock high for 5 cycles then low during STABILIZE: retry_count_o=1, state returns to RESET_PLL, sys_rst_n_o stays 0.
  - A second stable lock (>=8 cycles) reaches RUN with retry_count_o=0.
- Loss in RUN:
  - Drop pll_lock_i after RUN is reached.
  - 2 cycles after the drop plus 1: lost_lock_o is high for 1 cycle, sys_rst_n_o=0, locked_o=0.
  - pll_reset_o is reasserted for 4 cycles; retry_count_o stays 0.
- Async reset mid-STABILIZE:
  - Assert rst_n with no clock edge: all outputs reach reset values immediately.
  - After release, the full sequence restarts from RESET_PLL.
- Boundary:
  - Lock rises on exactly cycle 19 of WAIT_LOCK (timeout cycle): go to STABILIZE, no retry increment.
